// File: rtl/shift_add_multiplier.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : shift_add_multiplier                                       |
// | Description : Multicycle signed radix-2 shift-and-add multiplier.        |
// |               Operates on operand magnitudes, then applies the product   |
// |               sign and overflow detection in a single-cycle DONE step.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module shift_add_multiplier #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int              c_pw       = 2 * WIDTH;
  localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q,   state_d;
  logic [CNT_W-1:0]  counter_q, counter_d;
  logic [c_pw-1:0]   mcand_q,   mcand_d;
  logic [WIDTH-1:0]  mplier_q,  mplier_d;
  logic [c_pw-1:0]   acc_q,     acc_d;
  logic              sign_q,    sign_d;
  logic [WIDTH-1:0]  result_q,  result_d;
  logic              exc_q,     exc_d;
  logic              rdy_q,     rdy_d;

  // Operand magnitudes; -2^(WIDTH-1) negates to itself, which is the
  // correct unsigned magnitude in WIDTH bits.
  logic [WIDTH-1:0]  w_mag_a;
  logic [WIDTH-1:0]  w_mag_b;
  logic              w_neg;
  logic [c_pw-1:0]   w_prod;
  logic [WIDTH:0]    w_prod_top;
  logic              w_overflow;

  // Magnitude, signed-product and overflow computation.
  always_comb begin
    w_mag_a    = data_operandA[WIDTH-1] ? (-data_operandA) : data_operandA;
    w_mag_b    = data_operandB[WIDTH-1] ? (-data_operandB) : data_operandB;
    // A zero magnitude product is always reported as non-negative.
    w_neg      = sign_q & (|acc_q);
    w_prod     = w_neg ? (-acc_q) : acc_q;
    // The product fits in signed WIDTH bits only when its upper WIDTH+1
    // bits are a pure sign extension.
    w_prod_top = w_prod[c_pw-1:WIDTH-1];
    w_overflow = ~((&w_prod_top) | ~(|w_prod_top));
  end

  // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    sign_d    = sign_q;
    result_d  = result_q;
    exc_d     = exc_q;
    rdy_d     = 1'b0;

    if (ctrl_MULT) begin
      // A start in any state (re)latches the operands; an operation in
      // flight is abandoned without a ready pulse.
      mcand_d   = {{WIDTH{1'b0}}, w_mag_a};
      mplier_d  = w_mag_b;
      sign_d    = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      acc_d     = '0;
      counter_d = '0;
      state_d   = RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
          end
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          if (counter_q == c_last_cnt) begin
            counter_d = '0;
            state_d   = DONE;
          end else begin
            counter_d = counter_q + CNT_W'(1);
          end
        end
        DONE: begin
          result_d = w_prod[WIDTH-1:0];
          exc_d    = w_overflow;
          rdy_d    = 1'b1;
          state_d  = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous active-low clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      counter_q <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      sign_q    <= 1'b0;
      result_q  <= '0;
      exc_q     <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      sign_q    <= sign_d;
      result_q  <= result_d;
      exc_q     <= exc_d;
      rdy_q     <= rdy_d;
    end
  end

  // Busy spans RUN and DONE, so it drops in the same cycle RDY rises.
  always_comb begin
    data_result    = result_q;
    data_exception = exc_q;
    data_resultRDY = rdy_q;
    busy           = (state_q != IDLE);
  end

endmodule
`default_nettype wire

// File: tb/tb_shift_add_multiplier.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_shift_add_multiplier                                    |
// | Description : Scoreboard bench for shift_add_multiplier.                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_shift_add_multiplier;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        ctrl  = 1'b0;
  logic [31:0] op_a  = '0;
  logic [31:0] op_b  = '0;
  logic [31:0] result;
  logic        exc;
  logic        rdy;
  logic        busy;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct packed {
    logic [31:0] res;
    logic        exc;
  } exp_t;

  exp_t sb[$];

  shift_add_multiplier #(.WIDTH(32), .CNT_W(5)) dut (
    .clock          (clk),
    .reset          (rst_n),
    .ctrl_MULT      (ctrl),
    .data_operandA  (op_a),
    .data_operandB  (op_b),
    .data_result    (result),
    .data_exception (exc),
    .data_resultRDY (rdy),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // Reference: full 64-bit signed product, truncated, range-checked.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    longint p;
    exp_t   e;
    p     = longint'($signed(a)) * longint'($signed(b));
    e.res = p[31:0];
    e.exc = (p > 64'sd2147483647) || (p < -64'sd2147483648);
    return e;
  endfunction

  // Scoreboard: every ready pulse must match the oldest outstanding start.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && rdy === 1'b1) begin
      if (sb.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL sb_unexpected_rdy: got rdy=1, expected no pulse");
      end else begin
        e = sb.pop_front();
        tests_run++;
        if (result !== e.res) begin
          tests_failed++;
          $display("FAIL sb_result: got %h, expected %h", result, e.res);
        end
        tests_run++;
        if (exc !== e.exc) begin
          tests_failed++;
          $display("FAIL sb_exception: got %b, expected %b", exc, e.exc);
        end
      end
    end
  end

  // Start one multiply and wait (bounded) for its ready pulse.
  // lat = cycles from the sampling edge to the RDY cycle, -1 on timeout.
  task automatic do_mult(input logic [31:0] a, input logic [31:0] b,
                         output int lat, output bit busy_ok);
    @(negedge clk);
    op_a = a;
    op_b = b;
    ctrl = 1'b1;
    sb.push_back(model(a, b));
    lat     = -1;
    busy_ok = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      ctrl = 1'b0;
      if (rdy === 1'b1) begin
        if (busy !== 1'b0) busy_ok = 1'b0;
        lat = k;
        break;
      end else if (busy !== 1'b1) begin
        busy_ok = 1'b0;
      end
    end
  endtask

  task automatic test_reset;
    #3;
    tests_run++;
    if ({result, exc, rdy, busy} !== 35'd0) begin
      tests_failed++;
      $display("FAIL reset_state: got res=%h exc=%b rdy=%b busy=%b, expected all 0",
               result, exc, rdy, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int lat;
    bit bok;
    do_mult(32'd6, 32'd7, lat, bok);
    tests_run++;
    if (lat !== 33) begin
      tests_failed++;
      $display("FAIL basic_latency: got %0d, expected 33", lat);
    end
    tests_run++;
    if (bok !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_busy: got profile_ok=%b, expected 1", bok);
    end
    tests_run++;
    if (result !== 32'd42 || exc !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_result: got %h/%b, expected 0000002a/0", result, exc);
    end
    @(negedge clk);
    tests_run++;
    if (rdy !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_rdy_width: got rdy=%b, expected 0", rdy);
    end
  endtask

  task automatic test_reset_mid_run;
    int pulses;
    @(negedge clk);
    op_a = 32'd5;
    op_b = 32'd3;
    ctrl = 1'b1;
    sb.push_back(model(32'd5, 32'd3));
    repeat (6) begin
      @(negedge clk);
      ctrl = 1'b0;
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({result, exc, rdy, busy} !== 35'd0) begin
      tests_failed++;
      $display("FAIL reset_mid_run: got res=%h exc=%b rdy=%b busy=%b, expected all 0",
               result, exc, rdy, busy);
    end
    sb.delete();
    @(negedge clk);
    rst_n  = 1'b1;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (rdy === 1'b1) pulses++;
    end
    tests_run++;
    if (pulses !== 0) begin
      tests_failed++;
      $display("FAIL reset_no_rdy: got %0d pulses, expected 0", pulses);
    end
  endtask

  task automatic run_table(input string name, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] er,
                           input logic ee);
    int lat;
    bit bok;
    do_mult(a, b, lat, bok);
    tests_run++;
    if (lat !== 33 || result !== er || exc !== ee) begin
      tests_failed++;
      $display("FAIL %s: got lat=%0d res=%h exc=%b, expected lat=33 res=%h exc=%b",
               name, lat, result, exc, er, ee);
    end
  endtask

  task automatic test_signs;
    run_table("sign_neg_pos", 32'hFFFF_FFFB, 32'd3,        32'hFFFF_FFF1, 1'b0);
    run_table("sign_neg_neg", 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'd16,       1'b0);
    run_table("sign_zero",    32'd0,         32'hFFFF_FFF7, 32'd0,        1'b0);
  endtask

  task automatic test_boundary;
    run_table("bnd_min_x1",   32'h8000_0000, 32'd1,         32'h8000_0000, 1'b0);
    run_table("bnd_min_xm1",  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    run_table("bnd_2p16_sq",  32'h0001_0000, 32'h0001_0000, 32'd0,         1'b1);
    run_table("bnd_max_x1",   32'h7FFF_FFFF, 32'd1,         32'h7FFF_FFFF, 1'b0);
    run_table("bnd_min_sq",   32'h8000_0000, 32'h8000_0000, 32'd0,         1'b1);
  endtask

  task automatic test_restart;
    int pulses;
    int first_k;
    logic [31:0] got;
    @(negedge clk);
    op_a = 32'd2;
    op_b = 32'd3;
    ctrl = 1'b1;
    sb.push_back(model(32'd2, 32'd3));
    pulses  = 0;
    first_k = -1;
    got     = '0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      ctrl = 1'b0;
      if (rdy === 1'b1) begin
        pulses++;
        if (first_k < 0) begin
          first_k = k;
          got     = result;
        end
      end
      if (k == 9) begin
        op_a = 32'd4;
        op_b = 32'd5;
        ctrl = 1'b1;
        sb.delete();
        sb.push_back(model(32'd4, 32'd5));
      end
    end
    tests_run++;
    if (pulses !== 1) begin
      tests_failed++;
      $display("FAIL restart_pulses: got %0d, expected 1", pulses);
    end
    tests_run++;
    if (first_k - 10 !== 33) begin
      tests_failed++;
      $display("FAIL restart_latency: got %0d, expected 33", first_k - 10);
    end
    tests_run++;
    if (got !== 32'd20) begin
      tests_failed++;
      $display("FAIL restart_result: got %h, expected 00000014", got);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    int lat2;
    bit bok;
    bit hold_ok;
    do_mult(32'd6, 32'd7, lat, bok);
    tests_run++;
    if (lat !== 33 || result !== 32'd42) begin
      tests_failed++;
      $display("FAIL b2b_first: got lat=%0d res=%h, expected lat=33 res=0000002a",
               lat, result);
    end
    // Still in the RDY cycle: the next start is issued immediately.
    op_a = 32'd9;
    op_b = 32'd9;
    ctrl = 1'b1;
    sb.push_back(model(32'd9, 32'd9));
    lat2    = -1;
    hold_ok = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      ctrl = 1'b0;
      if (rdy === 1'b1) begin
        lat2 = k;
        break;
      end else if (result !== 32'd42) begin
        hold_ok = 1'b0;
      end
    end
    tests_run++;
    if (lat2 !== 33) begin
      tests_failed++;
      $display("FAIL b2b_latency: got %0d, expected 33", lat2);
    end
    tests_run++;
    if (hold_ok !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_hold: got hold_ok=%b, expected 1", hold_ok);
    end
    tests_run++;
    if (result !== 32'd81) begin
      tests_failed++;
      $display("FAIL b2b_second: got %h, expected 00000051", result);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reset_mid_run();
    test_signs();
    test_boundary();
    test_restart();
    test_back_to_back();
    repeat (3) @(negedge clk);
    tests_run++;
    if (sb.size() !== 0) begin
      tests_failed++;
      $display("FAIL sb_drain: got %0d outstanding, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    tests_failed++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/shift_add_multiplier.md
Name: shift_add_multiplier

Overview:
Multicycle signed integer multiplier for the processor execute stage. It sits directly downstream of the logical-left-shift unit and reuses the same shift-left-by-one datapath for its multiplicand. On each iteration it conditionally accumulates the shifted multiplicand, giving a radix-2 shift-and-add product. The pipeline stalls on busy and takes the result on data_resultRDY.

Parameters:
WIDTH, 32, operand/result width in bits; iteration count equals WIDTH
CNT_W, 5, counter width, equal to log2(WIDTH)

Ports:
clock  input  1  system clock, rising-edge active
reset  input  1  asynchronous, active-low reset
ctrl_MULT  input  1  start pulse, sampled on rising clock edge
data_operandA  input  WIDTH  multiplicand, two's complement
data_operandB  input  WIDTH  multiplier, two's complement
data_result  output  WIDTH  low WIDTH bits of signed product
data_exception  output  1  product overflowed signed WIDTH range
data_resultRDY  output  1  one-cycle pulse, result valid
busy  output  1  high while iterating

Behaviour:
- Clocking and reset:
  - One clock domain.
  - reset low asynchronously forces: state=IDLE, counter=0, data_result=0, data_exception=0, data_resultRDY=0, busy=0, all internal registers=0.
  - Reset asserted mid-operation aborts the operation. No RDY pulse follows.
- States: IDLE, RUN, DONE.
  - IDLE: ctrl_MULT=1 at an edge latches the operands and goes to RUN. Latching:
    - mcand = |A| zero-extended to 2*WIDTH.
    - mplier = |B|.
    - sign = A[MSB] ^ B[MSB].
    - acc = 0, counter = 0.
  - RUN:
    - Each edge: if mplier[0], acc += mcand; then mcand <<= 1 (logical, zero fill), mplier >>= 1 (logical), counter++.
    - After WIDTH iterations (counter wraps WIDTH-1 -> 0), go to DONE.
  - DONE:
    - Single cycle. On the next edge, register the outputs and return to IDLE:
      - data_result = (sign ? -acc : acc)[WIDTH-1:0]
      - data_exception
      - data_resultRDY = 1
- Latency and pulse timing:
  - ctrl_MULT sampled at edge 0.
  - data_resultRDY high for exactly the cycle after edge WIDTH+1; that is 33 cycles at WIDTH=32.
  - data_resultRDY is low in every other cycle.
- busy:
  - High from the edge that samples ctrl_MULT through the edge that raises data_resultRDY.
  - Low while data_resultRDY is high.
- Magnitude:
  - |-2^(WIDTH-1)| = 2^(WIDTH-1), held unsigned in WIDTH bits. No overflow in the magnitude step.
- Exception:
  - Set when the signed 2*WIDTH-bit product lies outside [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - Equivalently, when the upper WIDTH+1 bits of the signed product are not all equal.
  - A zero product is never negative: sign is ignored when acc=0.
- Hold: data_result and data_exception hold their values until the next DONE. They are not cleared when a new operation starts.
- ctrl_MULT while busy (RUN or DONE):
  - Restarts: re-latches the operands, counter=0, state=RUN.
  - No RDY pulse is emitted for the aborted operation.
- ctrl_MULT in the same cycle data_resultRDY is high: accepted as a new start from IDLE.
- Inputs are sampled only at the start edge. Operand changes during RUN are ignored.

Test Plan:
- Reset: reset low mid-RUN (started 5*3) -> all outputs 0 immediately; no data_resultRDY within 40 cycles of release.
- Basic: A=6, B=7, pulse ctrl_MULT -> busy for 33 cycles; data_resultRDY one cycle at cycle 33; data_result=42, exception=0.
- Signs:
  - A=-5, B=3 -> result 0xFFFFFFF1 (-15), exception=0.
  - A=-4, B=-4 -> 16.
  - A=0, B=-9 -> 0, exception=0.
- Boundary:
  - A=0x80000000, B=1 -> 0x80000000, exception=0.
  - A=0x80000000, B=-1 -> result 0x80000000, exception=1.
  - A=0x10000, B=0x10000 -> result 0, exception=1.
  - A=0x7FFFFFFF, B=1 -> 0x7FFFFFFF, exception=0.
- Restart: start 2*3, re-pulse ctrl_MULT at cycle 10 with 4*5 -> exactly one RDY pulse, 33 cycles after the second start, result=20.
- Back-to-back: ctrl_MULT in the RDY cycle with 9*9 after 6*7 -> first RDY gives 42; second RDY 33 cycles later gives 81. data_result holds 42 throughout the second run.
